segment_density_monitor: RTL and testbench

// - Receive end of the LFSR_comb random segment-mask stream: sequential checker for the masks driving segment display.
// - Consumes a stream of per-frame segment masks (one bit per segment) over a window of frames.
// - Measures the fraction of segments ON over that window and decodes it back into the 4-bit probability code.
// - Sits beside the display-mask generator in test/self-check builds; flags a broken seed/LFSR path.

---
 rtl/segment_density_monitor_if.sv | 28 ++
 rtl/segment_density_monitor.sv | 107 ++++++++++
 tb/tb_segment_density_monitor.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/segment_density_monitor_if.sv
// Stream/result bundle between the segment-mask source, the density monitor and its consumer.
interface segment_density_monitor_if #(
  parameter int unsigned NB_SEGMENTS   = 120,
  parameter int unsigned WINDOW_FRAMES = 64,
  parameter int unsigned COUNTERSIZE   = 4
);
  localparam int unsigned OnesW = $clog2(NB_SEGMENTS * WINDOW_FRAMES + 1);

  logic                   start;
  logic                   abort;
  logic                   rnd_valid;
  logic [NB_SEGMENTS-1:0] rnd;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [OnesW-1:0]       ones_total;
  logic [COUNTERSIZE-1:0] est_code;

  modport master (
    output start, abort, rnd_valid, rnd, result_ready,
    input  busy, result_valid, ones_total, est_code
  );

  modport slave (
    input  start, abort, rnd_valid, rnd, result_ready,
    output busy, result_valid, ones_total, est_code
  );
endinterface

// File: rtl/segment_density_monitor.sv
// Counts ON segments over a window of frames and decodes the density into a probability code.
module segment_density_monitor #(
  parameter int unsigned NB_SEGMENTS   = 120,
  parameter int unsigned WINDOW_FRAMES = 64,
  parameter int unsigned COUNTERSIZE   = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  segment_density_monitor_if.slave bus
);
  localparam int unsigned Total = NB_SEGMENTS * WINDOW_FRAMES;
  localparam int unsigned AccW  = $clog2(Total + 1);
  localparam int unsigned PopW  = $clog2(NB_SEGMENTS + 1);
  localparam int unsigned FrmW  = $clog2(WINDOW_FRAMES);

  localparam logic [63:0] Th99 = 64'(Total) * 64'd99;
  localparam logic [63:0] Th94 = 64'(Total) * 64'd94;
  localparam logic [63:0] Th85 = 64'(Total) * 64'd85;
  localparam logic [63:0] Th75 = 64'(Total) * 64'd75;
  localparam logic [63:0] Th65 = 64'(Total) * 64'd65;
  localparam logic [63:0] Th55 = 64'(Total) * 64'd55;

  typedef enum logic [1:0] {StIdle, StAccum, StCalc, StDone} state_e;

  state_e                 r_state;
  logic [FrmW-1:0]        r_frames;
  logic [AccW-1:0]        r_acc;
  logic [AccW-1:0]        r_ones_total;
  logic [COUNTERSIZE-1:0] r_est_code;
  logic                   r_result_valid;

  logic [PopW-1:0]        w_pop;
  logic [63:0]            w_scaled;
  logic [COUNTERSIZE-1:0] w_code;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(NB_SEGMENTS); i++) begin
      w_pop = w_pop + PopW'(bus.rnd[i]);
    end
  end

  // Exact integer compare of 100*ones against K*Total avoids any division.
  assign w_scaled = 64'(r_acc) * 64'd100;

  always_comb begin
    if      (w_scaled >= Th99) w_code = COUNTERSIZE'(0);
    else if (w_scaled >= Th94) w_code = COUNTERSIZE'(1);
    else if (w_scaled >= Th85) w_code = COUNTERSIZE'(2);
    else if (w_scaled >= Th75) w_code = COUNTERSIZE'(3);
    else if (w_scaled >= Th65) w_code = COUNTERSIZE'(4);
    else if (w_scaled >= Th55) w_code = COUNTERSIZE'(5);
    else                       w_code = COUNTERSIZE'(6);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_frames       <= '0;
      r_acc          <= '0;
      r_ones_total   <= '0;
      r_est_code     <= '0;
      r_result_valid <= 1'b0;
    end else if (bus.abort && (r_state != StIdle)) begin
      r_state        <= StIdle;
      r_frames       <= '0;
      r_acc          <= '0;
      r_result_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // A frame arriving with start is deliberately dropped.
          if (bus.start) begin
            r_frames <= '0;
            r_acc    <= '0;
            r_state  <= StAccum;
          end
        end
        StAccum: begin
          if (bus.rnd_valid) begin
            r_acc    <= r_acc + AccW'(w_pop);
            r_frames <= r_frames + 1'b1;
            if (r_frames == FrmW'(WINDOW_FRAMES - 1)) r_state <= StCalc;
          end
        end
        StCalc: begin
          r_ones_total   <= r_acc;
          r_est_code     <= w_code;
          r_result_valid <= 1'b1;
          r_state        <= StDone;
        end
        StDone: begin
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy         = (r_state == StAccum) || (r_state == StCalc);
  assign bus.result_valid = r_result_valid;
  assign bus.ones_total   = r_ones_total;
  assign bus.est_code     = r_est_code;
endmodule

// File: tb/tb_segment_density_monitor.sv
// Directed and randomized checks of segment_density_monitor against a density/threshold model.
module tb_segment_density_monitor;
  localparam int unsigned NB = 120;
  localparam int unsigned W  = 64;
  localparam int unsigned CS = 4;

  logic clk;
  logic rst_n;

  segment_density_monitor_if #(.NB_SEGMENTS(NB), .WINDOW_FRAMES(W), .COUNTERSIZE(CS)) bus ();

  segment_density_monitor #(.NB_SEGMENTS(NB), .WINDOW_FRAMES(W), .COUNTERSIZE(CS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ones;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: first threshold percentage reached gives the code; below all gives 6.
  function automatic int model_code(input int ones);
    int th[6] = '{99, 94, 85, 75, 65, 55};
    for (int k = 0; k < 6; k++) begin
      if (longint'(ones) * 100 >= longint'(th[k]) * longint'(NB * W)) return k;
    end
    return 6;
  endfunction

  // Mask with exactly n ON bits at random positions.
  function automatic logic [NB-1:0] mask_n(input int n);
    logic [NB-1:0] m;
    logic          t;
    int            j;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    for (int i = NB - 1; i > 0; i--) begin
      j    = $urandom_range(i, 0);
      t    = m[i];
      m[i] = m[j];
      m[j] = t;
    end
    return m;
  endfunction

  // kind 0: n ones each frame; kind 1: alternate n/n+1; kind 2: random 50..120.
  task automatic feed(input int kind, input int n, input int gap, input bit start_with_frame);
    int cnt;
    bus.start = 1'b1;
    bus.rnd_valid = start_with_frame;
    bus.rnd = '1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rnd_valid = 1'b0;
    exp_ones = 0;
    for (int f = 0; f < int'(W); f++) begin
      for (int g = 0; g < gap; g++) begin
        bus.rnd_valid = 1'b0;
        bus.rnd = mask_n(NB);
        @(negedge clk);
      end
      case (kind)
        0:       cnt = n;
        1:       cnt = n + (f % 2);
        default: cnt = $urandom_range(120, 50);
      endcase
      exp_ones += cnt;
      bus.rnd_valid = 1'b1;
      bus.rnd = mask_n(cnt);
      @(negedge clk);
    end
    bus.rnd_valid = 1'b0;
  endtask

  task automatic finish_window(input string tag);
    chk({tag, "_calc_valid"}, 64'(bus.result_valid), 64'd0);
    chk({tag, "_calc_busy"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus.result_valid), 64'd1);
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_ones"}, 64'(bus.ones_total), 64'(exp_ones));
    chk({tag, "_code"}, 64'(bus.est_code), 64'(model_code(exp_ones)));
  endtask

  task automatic handshake(input string tag);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(bus.result_valid), 64'd0);
    chk({tag, "_ones_kept"}, 64'(bus.ones_total), 64'(exp_ones));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.rnd = '0;
    bus.result_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.result_valid), 64'd0);
    chk("rst_ones", 64'(bus.ones_total), 64'd0);
    chk("rst_code", 64'(bus.est_code), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle frames and abort in IDLE must have no effect.
    bus.rnd_valid = 1'b1;
    bus.rnd = '1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.rnd_valid = 1'b0;
    bus.abort = 1'b0;
    chk("idle_busy", 64'(bus.busy), 64'd0);

    feed(0, 120, 0, 1'b0);
    chk("t1_model", 64'(exp_ones), 64'd7680);
    finish_window("t1");
    handshake("t1");

    feed(0, 0, 0, 1'b0);
    finish_window("t2a");
    handshake("t2a");
    feed(0, 84, 0, 1'b0);
    finish_window("t2b");
    handshake("t2b");

    feed(0, 108, 0, 1'b0);
    finish_window("t3a");
    handshake("t3a");
    feed(1, 60, 0, 1'b0);
    finish_window("t3b");
    handshake("t3b");

    // Gapped frames and a frame coincident with start.
    feed(0, 120, 2, 1'b1);
    finish_window("t4");
    handshake("t4");

    // Consumer stalls; new starts and frames during DONE must not disturb the result.
    feed(2, 0, 0, 1'b0);
    finish_window("t5");
    for (int c = 0; c < 10; c++) begin
      bus.start = $urandom_range(1, 0) == 1;
      bus.rnd_valid = 1'b1;
      bus.rnd = mask_n($urandom_range(120, 0));
      @(negedge clk);
      chk("t5_hold_valid", 64'(bus.result_valid), 64'd1);
      chk("t5_hold_ones", 64'(bus.ones_total), 64'(exp_ones));
      chk("t5_hold_code", 64'(bus.est_code), 64'(model_code(exp_ones)));
    end
    bus.rnd_valid = 1'b0;
    bus.start = 1'b1;
    handshake("t5");
    bus.start = 1'b0;
    chk("t5_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("t5_idle_busy2", 64'(bus.busy), 64'd0);

    // Abort mid-accumulation.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int f = 0; f < 30; f++) begin
      bus.rnd_valid = 1'b1;
      bus.rnd = '1;
      @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    for (int f = 0; f < 40; f++) @(negedge clk);
    bus.rnd_valid = 1'b0;
    chk("t6_abort_busy", 64'(bus.busy), 64'd0);
    chk("t6_abort_valid", 64'(bus.result_valid), 64'd0);

    // Abort in DONE withdraws the result.
    feed(0, 100, 0, 1'b0);
    finish_window("t6d");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t6d_abort_valid", 64'(bus.result_valid), 64'd0);

    // Asynchronous reset mid-ACCUM clears outputs without a clock edge.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int f = 0; f < 10; f++) begin
      bus.rnd_valid = 1'b1;
      bus.rnd = '1;
      @(negedge clk);
    end
    bus.rnd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_busy", 64'(bus.busy), 64'd0);
    chk("t6_arst_ones", 64'(bus.ones_total), 64'd0);
    chk("t6_arst_valid", 64'(bus.result_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      feed(2, 0, r, 1'b0);
      finish_window("rand");
      handshake("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
